ram_stack_ctrl: RTL and testbench
=================================

Name: ram_stack_ctrl

Overview:
LIFO stack controller that sits directly upstream of the 16x8 scratch RAM. It owns the RAM's Address/in/WE/CS lines and consumes its out bus. It turns push/pop/replace requests from the CPU datapath into RAM write and read cycles, and tracks the stack pointer, full/empty status and sticky error flags. It releases the RAM bus (CS low) whenever it is idle.

Parameters:
AW, 4, RAM address width; stack depth = 2**AW
DW, 8, data width

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset, sampled on posedge clk
push  in  1  request: push din
pop  in  1  request: pop top of stack to dout
din  in  DW  data to push
clr_err  in  1  clears overflow/underflow
dout  out  DW  popped data, held until the next pop completes
valid  out  1  one-cycle pulse: dout updated this cycle
busy  out  1  high while an operation is in flight; requests are ignored
full  out  1  sp == 2**AW
empty  out  1  sp == 0
count  out  AW+1  current stack depth (sp)
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop/replace attempted while empty
ram_addr  out  AW  to RAM Address
ram_wdata  out  DW  to RAM in
ram_we  out  1  to RAM WE
ram_cs  out  1  to RAM CS
ram_rdata  in  DW  from RAM out (combinational read, Z when CS low)

Behaviour:
- Reset (rst_n low at a posedge): state=IDLE, sp=0, dout=0, valid=0, ram_we=0, ram_cs=0, ram_addr=0, ram_wdata=0, overflow=0, underflow=0. Resulting outputs: busy=0, empty=1, full=0, count=0.
- All RAM-side outputs are registered. busy = (state != IDLE). full, empty and count decode from sp.
- The FSM has four states: IDLE, WR, RD, RDWR.
- Requests are sampled only in IDLE with busy=0.
- push only, not full:
  - State goes to WR.
  - Registers ram_addr=sp[AW-1:0], ram_wdata=din, ram_we=1, ram_cs=1.
  - The RAM writes on the next posedge. At that edge sp increments and the FSM returns to IDLE with we/cs=0.
  - Push latency: 2 edges; busy high for 1 cycle.
- pop only, not empty:
  - State goes to RD.
  - Registers ram_addr=sp-1, ram_cs=1, ram_we=0.
  - At the next edge: dout <= ram_rdata, valid=1 for one cycle, sp decrements, cs=0, return to IDLE.
- push and pop together, not empty (replace):
  - State goes to RD, then RDWR.
  - RD: ram_addr=sp-1, cs=1, we=0.
  - RD -> RDWR edge: dout <= ram_rdata, valid=1, ram_wdata=din (captured at accept), ram_we=1, addr unchanged.
  - RDWR -> IDLE edge: the RAM writes; sp is unchanged; we/cs=0.
  - din is latched at the accept edge, so later changes to din are ignored.
- push while full: no RAM access, overflow<=1, stays IDLE.
- pop or replace while empty: no RAM access, underflow<=1, stays IDLE, dout unchanged, no valid.
- Requests while busy are dropped without effect (the caller must hold or retry).
- clr_err clears both flags. If a new error occurs on the same edge, the set wins.
- sp never wraps: it saturates logically at 0 and 2**AW because the guards above block the access.
- Reset mid-operation:
  - The RAM has no reset. A write whose we=1 was already registered still lands at the reset edge.
  - The controller returns to the reset state regardless, and no valid is emitted.
- ram_cs=0 in IDLE, so the RAM drives Z on the shared out bus.

Decomposition:
- Shared package holds the FSM state enum {IDLE, WR, RD, RDWR} and the AW/DW defaults.
- No sub-module is needed: a single FSM plus sp counter. Testbenches instantiate it together with the existing ram module.

Test Plan:
- Reset, then push 8'h0A, 8'h0B, 8'h0C, each accepted with busy=0 -> count=3, RAM[0..2]=0A,0B,0C; busy high exactly 1 cycle per push.
- After the above, pop -> valid pulse 2 edges after accept, dout=0C, count=2; second pop -> dout=0B, count=1.
- Replace with din=8'h55 at count=1 -> dout=0A with valid, then RAM[0]=55, count stays 1; a following pop returns 55.
- 16 pushes of 8'h10..8'h1F, then a 17th push -> full=1, overflow=1, count=16, RAM unchanged; clr_err -> overflow=0.
- Pop at count=0 -> underflow=1, ram_cs never asserted, no valid.
- Push accepted, then pop asserted during the WR cycle -> the pop is ignored and count=+1. Also: rst_n low during RD -> count=0, valid never pulses, ram_cs=0 next cycle.

Source files
------------

// File: rtl/ram_stack_ctrl_pkg.sv
// Shared types and default geometry for the RAM-backed LIFO stack controller.
package ram_stack_ctrl_pkg;

  localparam int STK_AW = 4;
  localparam int STK_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RDWR = 2'd3
  } stk_state_t;

endpackage

// File: rtl/ram_stack_ctrl.sv
// LIFO stack controller driving a single-port scratch RAM; push, pop and
// replace (pop + push in place) with sticky overflow/underflow flags.
//
// state | meaning
// IDLE  | RAM released (cs=0), requests sampled
// WR    | write of pushed word at sp in progress, sp increments on exit
// RD    | read of top word at sp-1, dout/valid update on exit
// RDWR  | replace: overwrite top word with latched din, sp unchanged
module ram_stack_ctrl
  import ram_stack_ctrl_pkg::*;
#(
  parameter int AW = STK_AW,
  parameter int DW = STK_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  input  logic          clr_err,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          busy,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_cs,
  input  logic [DW-1:0] ram_rdata
);

  localparam logic [AW:0] SP_MAX = {1'b1, {AW{1'b0}}};

  stk_state_t  state;
  logic [AW:0] sp;
  logic        replace;
  logic [AW:0] sp_dec;

  assign sp_dec = sp - (AW+1)'(1);
  assign busy   = (state != IDLE);
  assign full   = (sp == SP_MAX);
  assign empty  = (sp == '0);
  assign count  = sp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      sp        <= '0;
      replace   <= 1'b0;
      dout      <= '0;
      valid     <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_we    <= 1'b0;
      ram_cs    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      valid <= 1'b0;
      // Clear first so that an error raised on the same edge survives.
      if (clr_err) begin
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (push && !pop) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              state     <= WR;
              ram_addr  <= sp[AW-1:0];
              ram_wdata <= din;
              ram_we    <= 1'b1;
              ram_cs    <= 1'b1;
            end
          end else if (pop) begin
            if (empty) begin
              underflow <= 1'b1;
            end else begin
              state    <= RD;
              ram_addr <= sp_dec[AW-1:0];
              ram_we   <= 1'b0;
              ram_cs   <= 1'b1;
              replace  <= push;
              // Replace data is held in ram_wdata; harmless while we=0.
              if (push) ram_wdata <= din;
            end
          end
        end
        WR: begin
          sp     <= sp + (AW+1)'(1);
          ram_we <= 1'b0;
          ram_cs <= 1'b0;
          state  <= IDLE;
        end
        RD: begin
          dout  <= ram_rdata;
          valid <= 1'b1;
          if (replace) begin
            ram_we <= 1'b1;
            state  <= RDWR;
          end else begin
            sp     <= sp_dec;
            ram_cs <= 1'b0;
            state  <= IDLE;
          end
        end
        RDWR: begin
          ram_we <= 1'b0;
          ram_cs <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stack_ctrl.sv
// Bench for ram_stack_ctrl: behavioural 16x8 RAM plus a queue-based stack
// model; directed scenarios followed by randomized push/pop/replace traffic.
module tb_ram_stack_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 2**AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          push, pop, clr_err;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          valid, busy, full, empty, overflow, underflow;
  logic [AW:0]   count;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          ram_we, ram_cs;

  ram_stack_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(din),
    .clr_err(clr_err), .dout(dout), .valid(valid), .busy(busy),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .underflow(underflow), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_cs(ram_cs), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Scratch RAM: combinational read, write on posedge with cs & we.
  logic [DW-1:0] mem [DEPTH];
  assign ram_rdata = ram_cs ? mem[ram_addr] : '0;
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;

  // Reference model
  logic [DW-1:0] stk[$];
  logic          m_ovf, m_unf;
  logic [DW-1:0] m_dout;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dout = '0;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"}, 32'(count), stk.size());
    chk({tag, "_full"}, 32'(full), 32'(stk.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(stk.size() == 0));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_unf"}, 32'(underflow), 32'(m_unf));
    chk({tag, "_dout"}, 32'(dout), 32'(m_dout));
    for (int i = 0; i < stk.size(); i++) chk({tag, "_ram"}, 32'(mem[i]), 32'(stk[i]));
  endtask

  // One request held for a single cycle from IDLE, observed for 6 cycles.
  task automatic run_op(input string tag, input bit p, input bit q, input bit c,
                        input logic [DW-1:0] d);
    int bc, vc, exp_bc, exp_vc;
    bit cs_seen, exp_cs, ovf_set, unf_set;
    logic [DW-1:0] vd;
    exp_bc = 0; exp_vc = 0; exp_cs = 0; ovf_set = 0; unf_set = 0; vd = '0;
    if (p && !q) begin
      if (stk.size() == DEPTH) ovf_set = 1;
      else begin stk.push_back(d); exp_bc = 1; exp_cs = 1; end
    end else if (q) begin
      if (stk.size() == 0) unf_set = 1;
      else if (p) begin
        m_dout = stk[stk.size()-1];
        stk[stk.size()-1] = d;
        exp_bc = 2; exp_vc = 1; exp_cs = 1;
      end else begin
        m_dout = stk.pop_back();
        exp_bc = 1; exp_vc = 1; exp_cs = 1;
      end
    end
    if (c) begin m_ovf = 0; m_unf = 0; end
    m_ovf = m_ovf | ovf_set;
    m_unf = m_unf | unf_set;

    push = p; pop = q; clr_err = c; din = d;
    @(posedge clk); @(negedge clk);
    push = 0; pop = 0; clr_err = 0; din = DW'($urandom);
    bc = 0; vc = 0; cs_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (valid) begin vc++; vd = dout; end
      if (ram_cs) cs_seen = 1;
      if (busy) bc++;
      @(posedge clk); @(negedge clk);
    end
    chk({tag, "_busy_cyc"}, bc, exp_bc);
    chk({tag, "_valid_cnt"}, vc, exp_vc);
    chk({tag, "_cs_seen"}, 32'(cs_seen), 32'(exp_cs));
    if (exp_vc == 1) chk({tag, "_valid_dout"}, 32'(vd), 32'(m_dout));
    chk_status(tag);
  endtask

  initial begin
    int base;
    rst_n = 0; push = 0; pop = 0; clr_err = 0; din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_cs", 32'(ram_cs), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_wdata", 32'(ram_wdata), 0);
    chk_status("rst");
    rst_n = 1;
    @(negedge clk);

    run_op("push0A", 1, 0, 0, 8'h0A);
    run_op("push0B", 1, 0, 0, 8'h0B);
    run_op("push0C", 1, 0, 0, 8'h0C);
    run_op("pop1", 0, 1, 0, 8'h00);
    run_op("pop2", 0, 1, 0, 8'h00);
    run_op("repl55", 1, 1, 0, 8'h55);
    run_op("pop55", 0, 1, 0, 8'h00);
    run_op("pop_empty", 0, 1, 0, 8'h00);
    run_op("repl_empty", 1, 1, 0, 8'h99);
    run_op("clr_unf", 0, 0, 1, 8'h00);

    // A pop raised while the push is still writing must be dropped.
    base = stk.size();
    push = 1; din = 8'hA5;
    @(posedge clk); @(negedge clk);
    push = 0; pop = 1;
    chk("drop_busy", 32'(busy), 1);
    @(posedge clk); @(negedge clk);
    pop = 0;
    stk.push_back(8'hA5);
    chk("drop_idle", 32'(busy), 0);
    chk("drop_count", 32'(count), base + 1);
    for (int i = 0; i < 3; i++) begin
      chk("drop_no_valid", 32'(valid), 0);
      chk("drop_no_busy", 32'(busy), 0);
      @(posedge clk); @(negedge clk);
    end
    chk_status("drop");

    // Reset while a pop read is outstanding.
    pop = 1;
    @(posedge clk); @(negedge clk);
    pop = 0; rst_n = 0;
    chk("rstrd_busy", 32'(busy), 1);
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    model_reset();
    chk("rstrd_valid", 32'(valid), 0);
    chk("rstrd_cs", 32'(ram_cs), 0);
    chk("rstrd_busy0", 32'(busy), 0);
    chk_status("rstrd");
    @(posedge clk); @(negedge clk);
    chk("rstrd_valid2", 32'(valid), 0);

    // Reset while a push write is registered: the write still lands.
    run_op("push77", 1, 0, 0, 8'h77);
    push = 1; din = 8'h3C;
    @(posedge clk); @(negedge clk);
    push = 0; rst_n = 0;
    chk("rstwr_we", 32'(ram_we), 1);
    @(posedge clk); @(negedge clk);
    rst_n = 1;
    chk("rstwr_ram", 32'(mem[1]), 32'h3C);
    model_reset();
    chk_status("rstwr");

    for (int i = 0; i < DEPTH; i++) run_op("fill", 1, 0, 0, DW'(8'h10 + i));
    run_op("push_full", 1, 0, 0, 8'hEE);
    run_op("push_full_clr", 1, 0, 1, 8'hEF);
    run_op("repl_full", 1, 1, 0, 8'h42);
    run_op("clr_ovf", 0, 0, 1, 8'h00);

    for (int i = 0; i < 300; i++) begin
      bit p, q, c;
      int bias;
      bias = (i < 150) ? 70 : 35;
      p = ($urandom_range(0, 99) < bias);
      q = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 11) == 0);
      run_op("rand", p, q, c, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
